// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the MIPS data-side bus responder: peripheral
// register offsets, TCON bit positions and the access-target decode.
package mem_bus_responder_pkg;

  // Byte offsets inside the 32-byte peripheral window.
  localparam logic [4:0] TH_OFF   = 5'h00;
  localparam logic [4:0] TL_OFF   = 5'h04;
  localparam logic [4:0] TCON_OFF = 5'h08;
  localparam logic [4:0] LED_OFF  = 5'h0C;
  localparam logic [4:0] SW_OFF   = 5'h10;
  localparam logic [4:0] DIGI_OFF = 5'h14;

  // The window spans 2**PERIPH_SPAN_LOG2 bytes starting at PERIPH_BASE.
  localparam int PERIPH_SPAN_LOG2 = 5;

  // TCON bit indices.
  localparam int TCON_EN = 0;  // timer enable
  localparam int TCON_IE = 1;  // interrupt enable
  localparam int TCON_IS = 2;  // interrupt status

  localparam int TCON_W = 3;
  localparam int LED_W  = 8;
  localparam int DIGI_W = 12;

  // Which storage element a bus access lands on.
  typedef enum logic [2:0] {
    TGT_NONE,
    TGT_RAM,
    TGT_TH,
    TGT_TL,
    TGT_TCON,
    TGT_LED,
    TGT_SW,
    TGT_DIGI
  } target_e;

  // Map a word index inside the peripheral window to its register.
  function automatic target_e periph_target(input logic [2:0] word);
    target_e t;
    t = TGT_NONE;
    case (word)
      TH_OFF[4:2]:   t = TGT_TH;
      TL_OFF[4:2]:   t = TGT_TL;
      TCON_OFF[4:2]: t = TGT_TCON;
      LED_OFF[4:2]:  t = TGT_LED;
      SW_OFF[4:2]:   t = TGT_SW;
      DIGI_OFF[4:2]: t = TGT_DIGI;
      default:       t = TGT_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mem_timer.sv
// Reloading 32-bit timer: TH holds the reload value, TL counts up while
// enabled, TCON carries enable / interrupt-enable / interrupt-status.
module mem_timer
  import mem_bus_responder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              th_we,
  input  logic              tl_we,
  input  logic              tcon_we,
  input  logic [31:0]       wdata,
  output logic [31:0]       th,
  output logic [31:0]       tl,
  output logic [TCON_W-1:0] tcon,
  output logic              irqout
);

  logic [31:0]       th_q, th_d;
  logic [31:0]       tl_q, tl_d;
  logic [TCON_W-1:0] tcon_q, tcon_d;
  logic              reload;

  // Next-state: CPU writes take priority over counting and status setting;
  // a reload always uses the TH value held before this edge.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    reload = tcon_q[TCON_EN] && (tl_q == '1);
    th_d   = th_we ? wdata : th_q;

    tl_d = tl_q;
    if (tl_we) begin
      tl_d = wdata;
    end else if (reload) begin
      tl_d = th_q;
    end else if (tcon_q[TCON_EN]) begin
      tl_d = tl_q + 32'd1;
    end

    tcon_d = tcon_q;
    if (tcon_we) begin
      tcon_d = wdata[TCON_W-1:0];
    end else if (reload && tcon_q[TCON_IE]) begin
      tcon_d[TCON_IS] = 1'b1;
    end
  end

  // Timer state registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignment so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th     = th_q;
  assign tl     = tl_q;
  assign tcon   = tcon_q;
  assign irqout = tcon_q[TCON_IE] & tcon_q[TCON_IS];

endmodule

// File: rtl/mem_bus_responder.sv
// Data-side bus responder for the pipelined MIPS core: data RAM plus a
// memory-mapped window with timer, LEDs, switches and 7-segment register.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int          RAM_WORDS   = 256,
  parameter logic [31:0] PERIPH_BASE = 32'h4000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRd,
  input  logic              MemWr,
  input  logic [31:0]       Addr,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  input  logic [LED_W-1:0]  switch,
  output logic [LED_W-1:0]  led,
  output logic [DIGI_W-1:0] digi,
  output logic              irqout
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]       ram [RAM_WORDS];
  logic [AW-1:0]     ram_idx;
  target_e           tgt;
  logic [LED_W-1:0]  led_q, led_d;
  logic [DIGI_W-1:0] digi_q, digi_d;
  logic [31:0]       th, tl;
  logic [TCON_W-1:0] tcon;
  logic              unused_addr_bits;

  // Accesses are whole words; the byte offset is ignored.
  assign unused_addr_bits = ^Addr[1:0];
  assign ram_idx          = Addr[AW+1:2];

  // Address decode: RAM at the bottom, peripheral window at PERIPH_BASE.
  always_comb begin
    tgt = TGT_NONE;
    if (Addr[31:AW+2] == '0) begin
      tgt = TGT_RAM;
    end else if (Addr[31:PERIPH_SPAN_LOG2] == PERIPH_BASE[31:PERIPH_SPAN_LOG2]) begin
      tgt = periph_target(Addr[4:2]);
    end
  end

  // Data RAM write port; contents are left undefined at power-up.
  always_ff @(posedge clk) begin
    // NOTE: the RAM has no reset so it maps onto block memory; software
    // must write a location before reading it.
    if (MemWr && tgt == TGT_RAM) begin
      ram[ram_idx] <= WriteData;
    end
  end

  // Next-state for the LED and 7-segment registers.
  always_comb begin
    led_d  = (MemWr && tgt == TGT_LED)  ? WriteData[LED_W-1:0]  : led_q;
    digi_d = (MemWr && tgt == TGT_DIGI) ? WriteData[DIGI_W-1:0] : digi_q;
  end

  // LED and 7-segment registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q  <= '0;
      digi_q <= '0;
    end else begin
      led_q  <= led_d;
      digi_q <= digi_d;
    end
  end

  mem_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .th_we   (MemWr && tgt == TGT_TH),
    .tl_we   (MemWr && tgt == TGT_TL),
    .tcon_we (MemWr && tgt == TGT_TCON),
    .wdata   (WriteData),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon),
    .irqout  (irqout)
  );

  // Combinational read mux; returns the pre-write value on a read+write.
  always_comb begin
    ReadData = '0;
    if (MemRd) begin
      case (tgt)
        TGT_RAM:  ReadData = ram[ram_idx];
        TGT_TH:   ReadData = th;
        TGT_TL:   ReadData = tl;
        TGT_TCON: ReadData = {{(32-TCON_W){1'b0}}, tcon};
        TGT_LED:  ReadData = {{(32-LED_W){1'b0}}, led_q};
        TGT_SW:   ReadData = {{(32-LED_W){1'b0}}, switch};
        TGT_DIGI: ReadData = {{(32-DIGI_W){1'b0}}, digi_q};
        default:  ReadData = '0;
      endcase
    end
  end

  assign led  = led_q;
  assign digi = digi_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed self-checking bench for mem_bus_responder with a scoreboard queue.
module tb_mem_bus_responder;

  localparam logic [31:0] PB      = 32'h4000_0000;
  localparam logic [31:0] A_TH    = PB + 32'h00;
  localparam logic [31:0] A_TL    = PB + 32'h04;
  localparam logic [31:0] A_TCON  = PB + 32'h08;
  localparam logic [31:0] A_LED   = PB + 32'h0C;
  localparam logic [31:0] A_SW    = PB + 32'h10;
  localparam logic [31:0] A_DIGI  = PB + 32'h14;
  localparam logic [31:0] A_HOLE  = PB + 32'h18;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRd, MemWr;
  logic [31:0] Addr, WriteData, ReadData;
  logic [7:0]  switch, led;
  logic [11:0] digi;
  logic        irqout;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_item_t;

  sb_item_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  mem_bus_responder #(.RAM_WORDS(256), .PERIPH_BASE(32'h4000_0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRd     (MemRd),
    .MemWr     (MemWr),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .switch    (switch),
    .led       (led),
    .digi      (digi),
    .irqout    (irqout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_q.push_back('{tag, val});
  endtask

  task automatic check_obs(input logic [31:0] obs);
    sb_item_t it;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %h expected <none>", obs);
    end else begin
      it = exp_q.pop_front();
      assert (obs === it.val) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", it.tag, obs, it.val);
      end
    end
  endtask

  // One bus cycle each: inputs change on the falling edge, the next rising
  // edge acts on them, outputs are sampled 2 ns after the falling edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    MemRd = 1'b0; MemWr = 1'b1; Addr = a; WriteData = d;
  endtask

  task automatic idle();
    @(negedge clk);
    MemRd = 1'b0; MemWr = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    MemRd = 1'b1; MemWr = 1'b0; Addr = a;
    push_exp(tag, exp);
    #2 check_obs(ReadData);
  endtask

  // Sampled within the current cycle, right after rd().
  task automatic chk_irq(input logic exp, input string tag);
    push_exp(tag, {31'd0, exp});
    check_obs({31'd0, irqout});
  endtask

  initial begin
    reset = 1'b1; MemRd = 1'b0; MemWr = 1'b0;
    Addr = '0; WriteData = '0; switch = 8'hA5;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state.
    @(negedge clk);
    MemRd = 1'b0; Addr = A_SW;
    push_exp("rd_idle_zero", 32'h0);
    #2 check_obs(ReadData);
    push_exp("led_port_rst", 32'h0);  check_obs({24'd0, led});
    push_exp("digi_port_rst", 32'h0); check_obs({20'd0, digi});
    rd(A_TH,   32'h0, "th_rst");
    rd(A_TL,   32'h0, "tl_rst");
    rd(A_TCON, 32'h0, "tcon_rst");
    rd(A_LED,  32'h0, "led_rst");
    rd(A_DIGI, 32'h0, "digi_rst");
    chk_irq(1'b0, "irq_rst");

    // RAM store / load, byte offset ignored, read-during-write.
    wr(32'h10, 32'h1234_5678);
    rd(32'h10, 32'h1234_5678, "ram_rd_10");
    rd(32'h13, 32'h1234_5678, "ram_rd_13");
    @(negedge clk);
    MemRd = 1'b1; MemWr = 1'b1; Addr = 32'h10; WriteData = 32'hAABB_CCDD;
    push_exp("ram_rdwr_old", 32'h1234_5678);
    #2 check_obs(ReadData);
    rd(32'h10, 32'hAABB_CCDD, "ram_rdwr_new");
    wr(32'h0,   32'h1111_1111);
    wr(32'h3FC, 32'h2222_2222);
    wr(32'h400, 32'hDEAD_BEEF);
    rd(32'h3FC, 32'h2222_2222, "ram_top_word");
    rd(32'h400, 32'h0,         "ram_past_end");
    rd(32'h0,   32'h1111_1111, "ram_no_alias");

    // Unmapped, read-only and register widths.
    wr(32'h2000_0000, 32'hCAFE_F00D);
    rd(32'h2000_0000, 32'h0, "unmapped_rd");
    wr(A_HOLE, 32'h1234_5678);
    rd(A_HOLE, 32'h0, "periph_hole_rd");
    wr(A_SW, 32'hFF);
    rd(A_SW, 32'h0000_00A5, "switch_rd");
    wr(A_LED, 32'h1FF);
    rd(A_LED, 32'h0000_00FF, "led_width");
    push_exp("led_port", 32'hFF); check_obs({24'd0, led});
    wr(A_DIGI, 32'hFFFF_FFFF);
    rd(A_DIGI, 32'h0000_0FFF, "digi_width");
    push_exp("digi_port", 32'hFFF); check_obs({20'd0, digi});
    wr(A_TCON, 32'hFFFF_FFF8);
    rd(A_TCON, 32'h0, "tcon_upper_zero");

    // Timer reload with interrupt enabled.
    wr(A_TH,   32'hFFFF_FFFC);
    wr(A_TL,   32'hFFFF_FFFE);
    wr(A_TCON, 32'h3);
    rd(A_TL, 32'hFFFF_FFFE, "tl_start");
    rd(A_TL, 32'hFFFF_FFFF, "tl_max");
    chk_irq(1'b0, "irq_before_reload");
    rd(A_TL, 32'hFFFF_FFFC, "tl_reload");
    chk_irq(1'b1, "irq_after_reload");
    rd(A_TCON, 32'h7, "tcon_status_set");
    wr(A_TCON, 32'h3);
    rd(A_TL, 32'hFFFF_FFFF, "tl_after_clear");
    chk_irq(1'b0, "irq_cleared");
    wr(A_TCON, 32'h0);

    // Timer reload with interrupt disabled.
    wr(A_TH,   32'hFFFF_FFFC);
    wr(A_TL,   32'hFFFF_FFFE);
    wr(A_TCON, 32'h1);
    rd(A_TL, 32'hFFFF_FFFE, "noie_tl_start");
    rd(A_TL, 32'hFFFF_FFFF, "noie_tl_max");
    rd(A_TL, 32'hFFFF_FFFC, "noie_tl_reload");
    chk_irq(1'b0, "noie_irq_low");
    rd(A_TCON, 32'h1, "noie_tcon");
    idle();                      // TL reaches FFFF_FFFF at this edge
    wr(A_TL, 32'h5);             // collides with the reload edge
    rd(A_TL, 32'h5, "collide_tl_write");
    rd(A_TL, 32'h6, "collide_tl_count");

    // Asynchronous reset between edges while the timer runs.
    wr(A_LED, 32'h3C);
    rd(A_LED, 32'h3C, "led_pre_reset");
    @(negedge clk);
    MemRd = 1'b1; MemWr = 1'b0; Addr = A_LED;
    #1 reset = 1'b1;
    #1 push_exp("async_led", 32'h0); check_obs(ReadData);
    Addr = A_TL;
    #1 push_exp("async_tl", 32'h0); check_obs(ReadData);
    Addr = A_TCON;
    #1 push_exp("async_tcon", 32'h0); check_obs(ReadData);
    reset = 1'b0;
    idle();
    idle();
    rd(A_TL, 32'h0, "tl_stays_after_reset");
    chk_irq(1'b0, "irq_after_reset");

    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
